// File: rtl/rs_scheduler_pkg.sv
// Shared constants and defaults for the reservation-station scheduler.
package rs_scheduler_pkg;

    localparam int DEF_TAG_W     = 6;
    localparam int DEF_PAYLOAD_W = 32;
    // Single CDB today; wakeup logic loops over this so it can be widened later.
    localparam int CDB_NUM       = 1;

endpackage : rs_scheduler_pkg

// File: rtl/rs_scheduler_age_matrix.sv
// Oldest-ready picker: age[k][j] = 1 means entry k was allocated after entry j.
module rs_age_matrix #(
    parameter int N = 2
) (
    input  logic [N-1:0] age [N],
    input  logic [N-1:0] rdy,
    output logic [N-1:0] oldest
);

    always_comb begin
        oldest = '0;
        for (int i = 0; i < N; i++) begin
            oldest[i] = rdy[i] & ~(|(age[i] & rdy));
        end
    end

endmodule : rs_age_matrix

// File: rtl/rs_scheduler_req_arbiter.sv
// Fixed-priority arbiter: grants the lowest-index asserted request, one-hot.
module req_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule : req_arbiter

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler for one FU: dispatch allocation, CDB wakeup, single issue.
// Define RS_AGE_ORDER_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_scheduler
    import rs_scheduler_pkg::*;
#(
    parameter int RS_ENT_NUM = 2,
    parameter int RS_ENT_SEL = 1,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int PAYLOAD_W  = DEF_PAYLOAD_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_dp_vld,
    input  logic [TAG_W-1:0]      i_dp_src1_tag,
    input  logic                  i_dp_src1_rdy,
    input  logic [TAG_W-1:0]      i_dp_src2_tag,
    input  logic                  i_dp_src2_rdy,
    input  logic [PAYLOAD_W-1:0]  i_dp_payload,
    output logic                  o_full,
    output logic [RS_ENT_SEL:0]   o_free_cnt,
    input  logic                  i_cdb_vld,
    input  logic [TAG_W-1:0]      i_cdb_tag,
    output logic                  o_issue_vld,
    output logic [RS_ENT_SEL-1:0] o_issue_sel,
    output logic [PAYLOAD_W-1:0]  o_issue_payload,
    input  logic                  i_issue_rdy
);

    logic [RS_ENT_NUM-1:0] vld;
    logic [RS_ENT_NUM-1:0] src1_rdy;
    logic [RS_ENT_NUM-1:0] src2_rdy;
    logic [TAG_W-1:0]      src1_tag [RS_ENT_NUM];
    logic [TAG_W-1:0]      src2_tag [RS_ENT_NUM];
    logic [PAYLOAD_W-1:0]  payload  [RS_ENT_NUM];

    logic [RS_ENT_NUM-1:0] rdy;
    logic [RS_ENT_NUM-1:0] free_vec;
    logic [RS_ENT_NUM-1:0] alloc_oh;
    logic [RS_ENT_NUM-1:0] sel_oh;
    logic [RS_ENT_NUM-1:0] wake1;
    logic [RS_ENT_NUM-1:0] wake2;
    logic                  dp_fire;
    logic                  iss_fire;
    logic                  dp_src1_rdy;
    logic                  dp_src2_rdy;
    logic [RS_ENT_SEL:0]   free_cnt;

    assign rdy      = vld & src1_rdy & src2_rdy;
    assign free_vec = ~vld;
    assign o_full   = &vld;
    assign dp_fire  = i_dp_vld & ~o_full;
    assign iss_fire = o_issue_vld & i_issue_rdy;

    req_arbiter #(.N(RS_ENT_NUM)) u_alloc_arb (
        .req (free_vec),
        .gnt (alloc_oh)
    );

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_ENT_NUM; i++) begin
            free_cnt = free_cnt + (RS_ENT_SEL + 1)'(free_vec[i]);
        end
    end
    assign o_free_cnt = free_cnt;

    // A source broadcast in the dispatch cycle must be captured by the new entry.
    always_comb begin
        wake1       = '0;
        wake2       = '0;
        dp_src1_rdy = i_dp_src1_rdy;
        dp_src2_rdy = i_dp_src2_rdy;
        for (int c = 0; c < CDB_NUM; c++) begin
            if (i_cdb_vld) begin
                for (int i = 0; i < RS_ENT_NUM; i++) begin
                    wake1[i] = wake1[i] | (src1_tag[i] == i_cdb_tag);
                    wake2[i] = wake2[i] | (src2_tag[i] == i_cdb_tag);
                end
                dp_src1_rdy = dp_src1_rdy | (i_dp_src1_tag == i_cdb_tag);
                dp_src2_rdy = dp_src2_rdy | (i_dp_src2_tag == i_cdb_tag);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld      <= '0;
            src1_rdy <= '0;
            src2_rdy <= '0;
            for (int i = 0; i < RS_ENT_NUM; i++) begin
                src1_tag[i] <= '0;
                src2_tag[i] <= '0;
                payload[i]  <= '0;
            end
        end else if (i_flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < RS_ENT_NUM; i++) begin
                if (wake1[i]) src1_rdy[i] <= 1'b1;
                if (wake2[i]) src2_rdy[i] <= 1'b1;
                if (iss_fire && sel_oh[i]) vld[i] <= 1'b0;
                // The allocated entry is free, so it never collides with the issuing one.
                if (dp_fire && alloc_oh[i]) begin
                    vld[i]      <= 1'b1;
                    src1_tag[i] <= i_dp_src1_tag;
                    src2_tag[i] <= i_dp_src2_tag;
                    src1_rdy[i] <= dp_src1_rdy;
                    src2_rdy[i] <= dp_src2_rdy;
                    payload[i]  <= i_dp_payload;
                end
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    logic [RS_ENT_NUM-1:0] age [RS_ENT_NUM];

    // New entry is younger than every live one; older rows forget the reused slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < RS_ENT_NUM; r++) age[r] <= '0;
        end else if (i_flush) begin
            for (int r = 0; r < RS_ENT_NUM; r++) age[r] <= '0;
        end else if (dp_fire) begin
            for (int r = 0; r < RS_ENT_NUM; r++) begin
                if (alloc_oh[r]) age[r] <= vld;
                else             age[r] <= age[r] & ~alloc_oh;
            end
        end
    end

    rs_age_matrix #(.N(RS_ENT_NUM)) u_age (
        .age    (age),
        .rdy    (rdy),
        .oldest (sel_oh)
    );
`else
    req_arbiter #(.N(RS_ENT_NUM)) u_sel_arb (
        .req (rdy),
        .gnt (sel_oh)
    );
`endif

    always_comb begin
        o_issue_sel     = '0;
        o_issue_payload = '0;
        for (int i = 0; i < RS_ENT_NUM; i++) begin
            if (sel_oh[i]) begin
                o_issue_sel     = RS_ENT_SEL'(i);
                o_issue_payload = payload[i];
            end
        end
    end
    assign o_issue_vld = |rdy;

endmodule : rs_scheduler

// File: tb/tb_rs_scheduler.sv
// Directed self-checking bench for rs_scheduler (default build, two entries).
module tb_rs_scheduler;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dp_vld;
    logic [5:0]  dp_src1_tag;
    logic        dp_src1_rdy;
    logic [5:0]  dp_src2_tag;
    logic        dp_src2_rdy;
    logic [31:0] dp_payload;
    logic        full;
    logic [1:0]  free_cnt;
    logic        cdb_vld;
    logic [5:0]  cdb_tag;
    logic        issue_vld;
    logic [0:0]  issue_sel;
    logic [31:0] issue_payload;
    logic        issue_rdy;

    int checks   = 0;
    int failures = 0;

    rs_scheduler #(
        .RS_ENT_NUM (2),
        .RS_ENT_SEL (1),
        .TAG_W      (6),
        .PAYLOAD_W  (32)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_dp_vld        (dp_vld),
        .i_dp_src1_tag   (dp_src1_tag),
        .i_dp_src1_rdy   (dp_src1_rdy),
        .i_dp_src2_tag   (dp_src2_tag),
        .i_dp_src2_rdy   (dp_src2_rdy),
        .i_dp_payload    (dp_payload),
        .o_full          (full),
        .o_free_cnt      (free_cnt),
        .i_cdb_vld       (cdb_vld),
        .i_cdb_tag       (cdb_tag),
        .o_issue_vld     (issue_vld),
        .o_issue_sel     (issue_sel),
        .o_issue_payload (issue_payload),
        .i_issue_rdy     (issue_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle 1 time unit past it.
    task automatic applyStimulus(input logic dv, input logic [5:0] t1, input logic r1,
                                 input logic [5:0] t2, input logic r2, input logic [31:0] pl,
                                 input logic cv, input logic [5:0] ct, input logic irdy,
                                 input logic fl);
        dp_vld      = dv;
        dp_src1_tag = t1;
        dp_src1_rdy = r1;
        dp_src2_tag = t2;
        dp_src2_rdy = r2;
        dp_payload  = pl;
        cdb_vld     = cv;
        cdb_tag     = ct;
        issue_rdy   = irdy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIssue(input string tag, input logic v, input logic s, input logic [31:0] pl);
        checkOutput({tag, "_vld"}, 32'(issue_vld), 32'(v));
        checkOutput({tag, "_sel"}, 32'(issue_sel), 32'(s));
        checkOutput({tag, "_pl"}, issue_payload, pl);
    endtask

    initial begin
        rst_n = 1'b0;
        dp_vld = 0; dp_src1_tag = 0; dp_src1_rdy = 0; dp_src2_tag = 0; dp_src2_rdy = 0;
        dp_payload = 0; cdb_vld = 0; cdb_tag = 0; issue_rdy = 0; flush = 0;
        #12;
        checkIssue("reset", 0, 0, 32'h0);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_cnt", 32'(free_cnt), 32'd2);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Ready-on-dispatch issues the next cycle, then frees.
        applyStimulus(1, 0, 1, 0, 1, 32'hA1, 0, 0, 1, 0);
        checkIssue("t1_issue", 1, 0, 32'hA1);
        checkOutput("t1_cnt", 32'(free_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t1_empty_vld", 32'(issue_vld), 32'd0);
        checkOutput("t1_empty_cnt", 32'(free_cnt), 32'd2);

        // Two entries wait on tag 5, one broadcast wakes both.
        applyStimulus(1, 5, 0, 0, 1, 32'hB0, 0, 0, 1, 0);
        checkOutput("t2_cnt1", 32'(free_cnt), 32'd1);
        checkOutput("t2_wait1", 32'(issue_vld), 32'd0);
        applyStimulus(1, 5, 0, 0, 1, 32'hB1, 0, 0, 1, 0);
        checkOutput("t2_full", 32'(full), 32'd1);
        checkOutput("t2_cnt0", 32'(free_cnt), 32'd0);
        checkOutput("t2_wait2", 32'(issue_vld), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 5, 1, 0);
        checkIssue("t2_first", 1, 0, 32'hB0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkIssue("t2_second", 1, 1, 32'hB1);
        checkOutput("t2_cnt_mid", 32'(free_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t2_done", 32'(issue_vld), 32'd0);

        // Dispatch while full is dropped; stalled FU loses nothing.
        applyStimulus(1, 0, 1, 0, 1, 32'hC0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 32'hC1, 0, 0, 0, 0);
        checkOutput("t3_full", 32'(full), 32'd1);
        applyStimulus(1, 0, 1, 0, 1, 32'hDD, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 32'hDD, 0, 0, 0, 0);
        checkOutput("t3_still_full", 32'(full), 32'd1);
        checkIssue("t3_hold", 1, 0, 32'hC0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkIssue("t3_after0", 1, 1, 32'hC1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        checkIssue("t3_stall", 1, 1, 32'hC1);
        checkOutput("t3_cnt", 32'(free_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t3_empty_vld", 32'(issue_vld), 32'd0);
        checkOutput("t3_empty_cnt", 32'(free_cnt), 32'd2);

        // CDB matching src2 in the dispatch cycle is captured.
        applyStimulus(1, 0, 1, 9, 0, 32'hE9, 1, 9, 1, 0);
        checkIssue("t4_capture", 1, 0, 32'hE9);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t4_done", 32'(issue_vld), 32'd0);

        // Flush beats dispatch and issue.
        applyStimulus(1, 0, 1, 0, 1, 32'hF0, 0, 0, 0, 0);
        checkOutput("t5_pre", 32'(issue_vld), 32'd1);
        applyStimulus(1, 0, 1, 0, 1, 32'hF1, 0, 0, 1, 1);
        checkIssue("t5_flush", 0, 0, 32'h0);
        checkOutput("t5_cnt", 32'(free_cnt), 32'd2);
        checkOutput("t5_full", 32'(full), 32'd0);

        // Only the matching tag wakes its own source.
        applyStimulus(1, 3, 0, 4, 0, 32'h77, 0, 0, 1, 0);
        checkOutput("t6_alloc_cnt", 32'(free_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 4, 1, 0);
        checkOutput("t6_half", 32'(issue_vld), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 7, 1, 0);
        checkOutput("t6_other_tag", 32'(issue_vld), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 3, 1, 0);
        checkIssue("t6_woken", 1, 0, 32'h77);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t6_done", 32'(free_cnt), 32'd2);

        // Higher index issues when lower waits; lower wins once ready.
        applyStimulus(1, 12, 0, 0, 1, 32'h60, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 32'h61, 0, 0, 0, 0);
        checkIssue("t7_only1", 1, 1, 32'h61);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 12, 0, 0);
        checkIssue("t7_lowest", 1, 0, 32'h60);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkIssue("t7_next", 1, 1, 32'h61);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t7_done", 32'(issue_vld), 32'd0);

        // Asynchronous reset drops live entries without a clock edge.
        applyStimulus(1, 0, 1, 0, 1, 32'h5A, 0, 0, 0, 0);
        checkOutput("t8_live", 32'(issue_vld), 32'd1);
        dp_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkIssue("t8_async", 0, 0, 32'h0);
        checkOutput("t8_cnt", 32'(free_cnt), 32'd2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        checkOutput("t8_after", 32'(issue_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rs_scheduler
